serializer_param: RTL and testbench
===================================

Name: serializer_param

Overview:
Parametrised parallel-to-serial converter, the next generation of the 8-bit serializer in the SerDes transmit path. Accepts WIDTH-bit words through a valid/ready handshake and emits them one bit per clock, with a per-word bit-order mode and a data-valid flag (DK-equivalent). It also emits start-of-word and end-of-word markers. A one-word holding buffer behind the shifter allows gap-free streaming of consecutive words.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32.
IDLE_BIT, 1'b0, value driven on out_bit whenever out_valid=0.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  in_data holds a word to transfer.
in_ready  output  1  block can accept a word this cycle.
in_data  input  WIDTH  parallel word.
in_msb_first  input  1  bit order for this word: 1=MSB first, 0=LSB first; sampled with the word.
out_bit  output  1  serial data.
out_valid  output  1  out_bit carries a word bit (DK).
out_sof  output  1  out_bit is the first bit of a word.
out_eof  output  1  out_bit is the last bit of a word.

Behaviour:
- Storage: shift register plus stored mode bit (shifter), one holding register plus mode bit (hold), bit counter of width $clog2(WIDTH), hold_full flag, shift_busy flag.
- Transfer occurs at a rising edge where in_valid=1 and in_ready=1. Combinationally, in_ready = !hold_full && !rst.
- Shifter states:
  - IDLE (shift_busy=0). An accepted word loads directly into the shifter and the state goes to SHIFT with counter=0.
  - SHIFT. Each clock the counter increments and the next bit is presented. At counter=WIDTH-1 (last bit):
    - if hold_full, the hold word moves into the shifter, the counter goes to 0, hold_full clears, and the state stays SHIFT;
    - else if a word is accepted at this same edge, it loads directly into the shifter and the state stays SHIFT;
    - else the state goes to IDLE.
  - In SHIFT before the last bit, an accepted word goes to hold and sets hold_full.
- Latency: a word accepted at edge k into an idle shifter presents its first bit in the cycle following edge k. Bit i appears in cycle k+1+i.
- Outputs are registered state, not combinational from in_*.
  - out_valid = shift_busy.
  - out_bit = shifter[WIDTH-1-counter] if mode=1, else shifter[counter]. out_bit = IDLE_BIT when out_valid=0.
  - out_sof = out_valid && counter==0.
  - out_eof = out_valid && counter==WIDTH-1.
- Throughput: with in_valid held high, successive words stream with zero idle cycles: out_valid is continuous, and eof of one word is immediately followed by sof of the next.
- Mode is per word: changing in_msb_first mid-word does not affect the word in flight or the word in hold.
- in_data/in_msb_first are ignored when no transfer occurs. No word is dropped or duplicated under any in_valid/in_ready pattern.
- Reset (any cycle, including mid-word or with hold full):
  - both words are discarded;
  - counter=0, hold_full=0, shift_busy=0;
  - out_valid=0, out_sof=0, out_eof=0, out_bit=IDLE_BIT;
  - in_ready=0 while rst=1 and 1 in the first cycle after rst deasserts;
  - no transfer is accepted in a cycle where rst=1.

Test Plan:
- WIDTH=8, rst then single word 0x1E, msb_first=1 -> out_bit 0,0,0,1,1,1,1,0 in cycles 1-8 after accept; out_sof cycle 1 only; out_eof cycle 8 only; then out_valid=0, out_bit=0.
- Same word 0x1E, msb_first=0 -> 0,1,1,1,1,0,0,0. Mode toggled mid-word -> output unchanged.
- Words 0x01 (MSB), 0xFF (LSB), 0x80 (MSB) offered back-to-back with in_valid=1 -> 24 contiguous valid bits 00000001_11111111_10000000. in_ready=0 whenever hold is full. Three sof and three eof pulses at bit offsets 0/7, 8/15, 16/23.
- Backpressure: in_valid held high with changing in_data while in_ready=0 -> only the words present at accept edges are serialized, in order.
- Reset asserted at bit 3 of 0xA5 with hold holding 0x3C -> next cycle out_valid=0 and out_bit=IDLE_BIT; after release a new word 0x0F serializes cleanly, and 0x3C never appears.
- WIDTH=10, IDLE_BIT=1: word 10'h2A5, MSB first -> 1,0,1,0,1,0,0,1,0,1, eof on bit 10; idle out_bit=1.

Source files
------------

// File: rtl/serializer_param_if.sv
// Word-in / bit-out bundle for the parametrised serializer.
// Latency: none, wires only.
// Backpressure: in_ready from the slave qualifies in_valid from the master.
interface serializer_param_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_msb_first;
   logic             out_bit;
   logic             out_valid;
   logic             out_sof;
   logic             out_eof;

   // Word producer side
   modport master (
      output in_valid, in_data, in_msb_first,
      input  in_ready, out_bit, out_valid, out_sof, out_eof
   );

   // Serializer side
   modport slave (
      input  in_valid, in_data, in_msb_first,
      output in_ready, out_bit, out_valid, out_sof, out_eof
   );
endinterface

// File: rtl/serializer_param.sv
// Parallel-to-serial converter: WIDTH-bit words out one bit per clock, per-word bit order, sof/eof markers.
// Latency: word accepted at edge k into an idle shifter shows bit i in cycle k+1+i.
// Backpressure: one-word hold buffer behind the shifter; in_ready drops only while hold is full or in reset.
module serializer_param #(
   parameter int   WIDTH    = 8,
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   serializer_param_if.slave  bus
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic             shift_msb_q, shift_msb_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_msb_q, hold_msb_d;
   logic             hold_full_q, hold_full_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             accept;
   logic             busy;
   logic [CW-1:0]    bit_idx;

   // Ready depends only on registered hold state and reset, never on in_valid.
   assign bus.in_ready = !hold_full_q && !rst;
   assign accept       = bus.in_valid && !hold_full_q && !rst;

   // Next-state: load idle shifter directly, park early arrivals in hold, refill at last bit.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      shift_msb_d = shift_msb_q;
      hold_d      = hold_q;
      hold_msb_d  = hold_msb_q;
      hold_full_d = hold_full_q;
      cnt_d       = cnt_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               shift_d     = bus.in_data;
               shift_msb_d = bus.in_msb_first;
               cnt_d       = '0;
               state_d     = SHIFT;
            end
         end

         SHIFT: begin
            if (cnt_q == LAST) begin
               cnt_d = '0;
               if (hold_full_q) begin
                  // Hold refills the shifter; in_ready is low so nothing is accepted here.
                  shift_d     = hold_q;
                  shift_msb_d = hold_msb_q;
                  hold_full_d = 1'b0;
               end else if (accept) begin
                  shift_d     = bus.in_data;
                  shift_msb_d = bus.in_msb_first;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (accept) begin
                  hold_d      = bus.in_data;
                  hold_msb_d  = bus.in_msb_first;
                  hold_full_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset discards both the word in flight and the held word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         shift_msb_q <= 1'b0;
         hold_q      <= '0;
         hold_msb_q  <= 1'b0;
         hold_full_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         shift_msb_q <= shift_msb_d;
         hold_q      <= hold_d;
         hold_msb_q  <= hold_msb_d;
         hold_full_q <= hold_full_d;
         cnt_q       <= cnt_d;
      end
   end

   // Serial outputs decode registered state only.
   assign busy          = (state_q == SHIFT);
   assign bit_idx       = shift_msb_q ? (LAST - cnt_q) : cnt_q;
   assign bus.out_valid = busy;
   assign bus.out_bit   = busy ? shift_q[bit_idx] : IDLE_BIT;
   assign bus.out_sof   = busy && (cnt_q == '0);
   assign bus.out_eof   = busy && (cnt_q == LAST);

endmodule

// File: tb/tb_serializer_param.sv
// Directed bench for serializer_param: WIDTH=8/IDLE_BIT=0 and WIDTH=10/IDLE_BIT=1 instances.
// Latency: expectations assume bit i of a word shows in cycle k+1+i after its accept edge k.
// Backpressure: feeder holds in_valid high and scrambles data whenever in_ready is low.
module tb_serializer_param;

   logic clk;
   logic rst;
   logic rst10;

   serializer_param_if #(.WIDTH(8))  bus8 ();
   serializer_param_if #(.WIDTH(10)) bus10 ();

   serializer_param #(.WIDTH(8), .IDLE_BIT(1'b0)) u8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   serializer_param #(.WIDTH(10), .IDLE_BIT(1'b1)) u10 (
      .clk (clk),
      .rst (rst10),
      .bus (bus10)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] got_bit, got_sof, got_eof, got_vld;
   int          nrdy;
   logic [8:0]  wq[$];   // {msb_first, data}

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Drive queued words into the 8-bit instance for n cycles, sampling outputs after each edge.
   task automatic run(input int n);
      logic rdy;
      got_bit = '0; got_sof = '0; got_eof = '0; got_vld = '0; nrdy = 0;
      for (int i = 0; i < n; i++) begin
         if (wq.size() > 0) begin
            bus8.in_valid = 1'b1;
            if (bus8.in_ready) begin
               bus8.in_data      = wq[0][7:0];
               bus8.in_msb_first = wq[0][8];
            end else begin
               bus8.in_data      = 8'($urandom);
               bus8.in_msb_first = 1'($urandom);
            end
         end else begin
            bus8.in_valid     = 1'b0;
            bus8.in_data      = 8'($urandom);
            bus8.in_msb_first = ~bus8.in_msb_first;
         end
         rdy = bus8.in_ready;
         if (!rdy) nrdy++;
         cyc();
         if (bus8.in_valid && rdy) void'(wq.pop_front());
         got_bit = {got_bit[62:0], bus8.out_bit};
         got_sof = {got_sof[62:0], bus8.out_sof};
         got_eof = {got_eof[62:0], bus8.out_eof};
         got_vld = {got_vld[62:0], bus8.out_valid};
      end
      bus8.in_valid = 1'b0;
   endtask

   task automatic chk_idle8(input string tag);
      chk({tag, "_vld"}, 64'(bus8.out_valid), 64'd0);
      chk({tag, "_bit"}, 64'(bus8.out_bit),   64'd0);
      chk({tag, "_sof"}, 64'(bus8.out_sof),   64'd0);
      chk({tag, "_eof"}, 64'(bus8.out_eof),   64'd0);
   endtask

   initial begin
      rst                = 1'b1;
      rst10              = 1'b1;
      bus8.in_valid      = 1'b1;
      bus8.in_data       = 8'hFF;
      bus8.in_msb_first  = 1'b1;
      bus10.in_valid     = 1'b0;
      bus10.in_data      = '0;
      bus10.in_msb_first = 1'b1;

      // Reset state, with in_valid asserted to show no transfer during reset
      cyc();
      cyc();
      chk("rst_ready", 64'(bus8.in_ready), 64'd0);
      chk_idle8("rst");
      chk("rst10_bit", 64'(bus10.out_bit),   64'd1);
      chk("rst10_vld", 64'(bus10.out_valid), 64'd0);

      rst           = 1'b0;
      bus8.in_valid = 1'b0;
      cyc();
      chk("post_rst_ready", 64'(bus8.in_ready),  64'd1);
      chk("no_accept_rst",  64'(bus8.out_valid), 64'd0);

      // Single word, MSB first
      wq.push_back({1'b1, 8'h1E});
      run(8);
      chk("w1e_msb_bits", got_bit, 64'h1E);
      chk("w1e_msb_sof",  got_sof, 64'h80);
      chk("w1e_msb_eof",  got_eof, 64'h01);
      chk("w1e_msb_vld",  got_vld, 64'hFF);
      cyc();
      chk_idle8("w1e_idle");

      // Same word LSB first; idle mode input toggles every cycle while it shifts
      wq.push_back({1'b0, 8'h1E});
      run(8);
      chk("w1e_lsb_bits", got_bit, 64'h78);
      chk("w1e_lsb_sof",  got_sof, 64'h80);
      chk("w1e_lsb_eof",  got_eof, 64'h01);
      cyc();

      // Back-to-back stream with mixed modes
      wq.push_back({1'b1, 8'h01});
      wq.push_back({1'b0, 8'hFF});
      wq.push_back({1'b1, 8'h80});
      run(24);
      chk("b2b_bits", got_bit, 64'h01FF80);
      chk("b2b_sof",  got_sof, 64'h808080);
      chk("b2b_eof",  got_eof, 64'h010101);
      chk("b2b_vld",  got_vld, 64'hFFFFFF);
      chk("b2b_nrdy", 64'(nrdy), 64'd14);
      cyc();
      chk_idle8("b2b_idle");

      // Backpressure with scrambled data while not ready
      wq.push_back({1'b0, 8'h35});
      wq.push_back({1'b1, 8'hC3});
      wq.push_back({1'b0, 8'h96});
      run(24);
      chk("bp_bits", got_bit, 64'hACC369);
      chk("bp_vld",  got_vld, 64'hFFFFFF);
      chk("bp_eof",  got_eof, 64'h010101);
      cyc();

      // Reset at bit 3 of 0xA5 with 0x3C in hold
      wq.push_back({1'b1, 8'hA5});
      wq.push_back({1'b1, 8'h3C});
      run(4);
      chk("a5_bits", got_bit, 64'hA);
      rst = 1'b1;
      cyc();
      chk_idle8("midrst");
      chk("midrst_ready", 64'(bus8.in_ready), 64'd0);
      rst = 1'b0;
      cyc();
      chk("midrst_rel_ready", 64'(bus8.in_ready),  64'd1);
      chk("midrst_rel_vld",   64'(bus8.out_valid), 64'd0);
      wq.push_back({1'b1, 8'h0F});
      run(8);
      chk("w0f_bits", got_bit, 64'h0F);
      chk("w0f_sof",  got_sof, 64'h80);
      chk("w0f_eof",  got_eof, 64'h01);
      run(10);
      chk("no_3c_vld", got_vld, 64'h0);

      // WIDTH=10, IDLE_BIT=1
      rst10 = 1'b0;
      cyc();
      chk("w10_ready", 64'(bus10.in_ready), 64'd1);
      chk("w10_idle0", 64'(bus10.out_bit),  64'd1);
      bus10.in_valid     = 1'b1;
      bus10.in_data      = 10'h2A5;
      bus10.in_msb_first = 1'b1;
      cyc();
      bus10.in_valid = 1'b0;
      bus10.in_data  = 10'h3FF;
      got_bit = '0; got_sof = '0; got_eof = '0; got_vld = '0;
      for (int i = 0; i < 10; i++) begin
         got_bit = {got_bit[62:0], bus10.out_bit};
         got_sof = {got_sof[62:0], bus10.out_sof};
         got_eof = {got_eof[62:0], bus10.out_eof};
         got_vld = {got_vld[62:0], bus10.out_valid};
         bus10.in_msb_first = ~bus10.in_msb_first;
         cyc();
      end
      chk("w10_bits", got_bit, 64'h2A5);
      chk("w10_sof",  got_sof, 64'h200);
      chk("w10_eof",  got_eof, 64'h001);
      chk("w10_vld",  got_vld, 64'h3FF);
      chk("w10_idle_bit", 64'(bus10.out_bit),   64'd1);
      chk("w10_idle_vld", 64'(bus10.out_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
